// File: rtl/multi_shift_reg.sv
// Multi-step shift/rotate register: parallel load, or a counted sequence of single-bit
// SLL/SRL/SRA/ROL/ROR steps with busy/done handshake.
module multi_shift_reg #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    input  logic             we,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [CNT_W-1:0] cnt,
    input  logic             sin,
    output logic [WIDTH-1:0] q,
    output logic             cout,
    output logic             busy,
    output logic             done
);

    typedef enum logic {StIdle, StRun} state_e;

    state_e           r_state, w_state_d;
    logic [WIDTH-1:0] r_q, w_q_d;
    logic             r_cout, w_cout_d;
    logic             r_done, w_done_d;
    logic [2:0]       r_op, w_op_d;
    logic [CNT_W-1:0] r_cnt, w_cnt_d;
    logic             r_sin, w_sin_d;

    logic [WIDTH-1:0] w_step_q;
    logic             w_step_cout;

    // One single-bit step using the latched operation; reserved ops hold.
    always_comb begin
        w_step_q    = r_q;
        w_step_cout = r_cout;
        case (r_op)
            3'b000: begin
                w_step_q    = {r_q[WIDTH-2:0], r_sin};
                w_step_cout = r_q[WIDTH-1];
            end
            3'b001: begin
                w_step_q    = {r_sin, r_q[WIDTH-1:1]};
                w_step_cout = r_q[0];
            end
            3'b010: begin
                w_step_q    = {r_q[WIDTH-1], r_q[WIDTH-1:1]};
                w_step_cout = r_q[0];
            end
            3'b011: begin
                w_step_q    = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
                w_step_cout = r_q[WIDTH-1];
            end
            3'b100: begin
                w_step_q    = {r_q[0], r_q[WIDTH-1:1]};
                w_step_cout = r_q[0];
            end
            default: begin
                w_step_q    = r_q;
                w_step_cout = r_cout;
            end
        endcase
    end

    always_comb begin
        w_state_d = r_state;
        w_q_d     = r_q;
        w_cout_d  = r_cout;
        w_done_d  = 1'b0;
        w_op_d    = r_op;
        w_cnt_d   = r_cnt;
        w_sin_d   = r_sin;
        case (r_state)
            StIdle: begin
                if (we) begin
                    w_q_d = d;
                end else if (start) begin
                    if (cnt == '0) begin
                        w_done_d = 1'b1;
                    end else begin
                        w_op_d    = op;
                        w_cnt_d   = cnt;
                        w_sin_d   = sin;
                        w_state_d = StRun;
                    end
                end
            end
            StRun: begin
                w_q_d    = w_step_q;
                w_cout_d = w_step_cout;
                w_cnt_d  = r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1)) begin
                    w_state_d = StIdle;
                    w_done_d  = 1'b1;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
            r_q     <= '0;
            r_cout  <= 1'b0;
            r_done  <= 1'b0;
            r_op    <= '0;
            r_cnt   <= '0;
            r_sin   <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_q     <= w_q_d;
            r_cout  <= w_cout_d;
            r_done  <= w_done_d;
            r_op    <= w_op_d;
            r_cnt   <= w_cnt_d;
            r_sin   <= w_sin_d;
        end
    end

    assign q    = r_q;
    assign cout = r_cout;
    assign busy = (r_state == StRun);
    assign done = r_done;

endmodule

// File: tb/tb_multi_shift_reg.sv
// Self-checking bench for multi_shift_reg: directed scenarios plus random operations
// compared against a closed-form shift/rotate reference model.
module tb_multi_shift_reg;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] d = '0;
    logic        we = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = '0;
    logic [3:0]  cnt = '0;
    logic        sin = 1'b0;
    logic [15:0] q;
    logic        cout;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] m_q = '0;
    logic        m_cout = 1'b0;

    multi_shift_reg #(.WIDTH(16), .CNT_W(4)) dut (
        .clk  (clk),
        .rst  (rst),
        .d    (d),
        .we   (we),
        .start(start),
        .op   (op),
        .cnt  (cnt),
        .sin  (sin),
        .q    (q),
        .cout (cout),
        .busy (busy),
        .done (done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Net effect of n steps, computed directly rather than step by step.
    function automatic logic [16:0] ref_op(input logic [15:0] q0, input logic c0, input int o,
                                           input int n, input logic s);
        logic [15:0] qn;
        logic        cn;
        int          r;
        qn = q0;
        cn = c0;
        r  = n % 16;
        if (n == 0) return {c0, q0};
        case (o)
            0: begin
                qn = q0 << n;
                if (s) qn = qn | (16'hFFFF >> (16 - n));
                cn = q0[16-n];
            end
            1: begin
                qn = q0 >> n;
                if (s) qn = qn | ~(16'hFFFF >> n);
                cn = q0[n-1];
            end
            2: begin
                qn = $signed(q0) >>> n;
                cn = q0[n-1];
            end
            3: begin
                qn = (q0 << r) | (q0 >> (16 - r));
                cn = qn[0];
            end
            4: begin
                qn = (q0 >> r) | (q0 << (16 - r));
                cn = qn[15];
            end
            default: ;
        endcase
        return {cn, qn};
    endfunction

    // All tasks start and end 1 time unit after a rising edge.
    task automatic do_load(input logic [15:0] v);
        we = 1'b1;
        start = 1'b0;
        d = v;
        @(posedge clk); #1;
        we = 1'b0;
        m_q = v;
        check_eq("load_q", 32'(q), 32'(m_q));
        check_eq("load_cout", 32'(cout), 32'(m_cout));
        check_eq("load_done", 32'(done), 32'd0);
    endtask

    task automatic do_op(input logic [2:0] o, input int n, input logic s, input bit disturb,
                         input bit b2b);
        logic [16:0] e;
        int busy_cyc;
        int waited;
        e = ref_op(m_q, m_cout, int'(o), n, s);
        op = o;
        cnt = 4'(n);
        sin = s;
        we = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        busy_cyc = 0;
        waited = 0;
        while (!done && waited < 40) begin
            if (busy) busy_cyc++;
            if (disturb) begin
                we = 1'($urandom);
                d = 16'($urandom);
                op = 3'($urandom);
                cnt = 4'($urandom);
                sin = 1'($urandom);
                start = 1'($urandom);
            end
            @(posedge clk); #1;
            waited++;
        end
        we = 1'b0;
        start = 1'b0;
        check_eq("op_done", 32'(done), 32'd1);
        check_eq("op_busy_end", 32'(busy), 32'd0);
        check_eq("op_busy_cycles", 32'(busy_cyc), 32'(n));
        check_eq("op_q", 32'(q), 32'(e[15:0]));
        check_eq("op_cout", 32'(cout), 32'(e[16]));
        m_q = e[15:0];
        m_cout = e[16];
        if (!b2b) begin
            @(posedge clk); #1;
            check_eq("done_width", 32'(done), 32'd0);
            check_eq("q_hold", 32'(q), 32'(m_q));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int dones;
        #3;
        check_eq("rst_q", 32'(q), 32'd0);
        check_eq("rst_cout", 32'(cout), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        do_load(16'h8001);
        do_op(3'd0, 1, 1'b0, 1'b0, 1'b0);
        check_eq("sll1_q", 32'(q), 32'h0002);
        do_load(16'h8000);
        do_op(3'd2, 4, 1'b0, 1'b0, 1'b0);
        check_eq("sra4_q", 32'(q), 32'hF800);
        do_load(16'hFFFF);
        do_op(3'd1, 8, 1'b0, 1'b0, 1'b0);
        check_eq("srl8_q", 32'(q), 32'h00FF);
        check_eq("srl8_cout", 32'(cout), 32'd1);
        do_load(16'h1234);
        do_op(3'd3, 4, 1'b0, 1'b0, 1'b0);
        check_eq("rol4_q", 32'(q), 32'h2341);
        do_load(16'h0001);
        do_op(3'd4, 15, 1'b0, 1'b0, 1'b0);
        check_eq("ror15_q", 32'(q), 32'h0002);
        check_eq("ror15_cout", 32'(cout), 32'd0);

        do_load(16'hABCD);
        do_op(3'd0, 0, 1'b1, 1'b0, 1'b0);
        check_eq("cnt0_q", 32'(q), 32'hABCD);

        // we and start together: load wins, no operation starts
        we = 1'b1;
        start = 1'b1;
        d = 16'h1357;
        op = 3'd3;
        cnt = 4'd5;
        @(posedge clk); #1;
        we = 1'b0;
        start = 1'b0;
        m_q = 16'h1357;
        check_eq("we_prio_q", 32'(q), 32'h1357);
        check_eq("we_prio_busy", 32'(busy), 32'd0);
        check_eq("we_prio_done", 32'(done), 32'd0);
        @(posedge clk); #1;
        check_eq("we_prio_done2", 32'(done), 32'd0);

        // disturbed run, then back-to-back start on the done cycle
        do_load(16'hC3A5);
        do_op(3'd0, 8, 1'b1, 1'b1, 1'b1);
        do_op(3'd4, 3, 1'b0, 1'b0, 1'b1);
        do_load(16'h0F0F);

        // reset during a ROL run after three steps
        do_load(16'h9ABC);
        op = 3'd3;
        cnt = 4'd10;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        #2;
        rst = 1'b1;
        #1;
        check_eq("abort_q", 32'(q), 32'd0);
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_cout", 32'(cout), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        m_q = '0;
        m_cout = 1'b0;
        dones = 0;
        repeat (12) begin
            if (done || busy) dones++;
            @(posedge clk); #1;
        end
        check_eq("abort_no_done", 32'(dones), 32'd0);
        do_load(16'h00F0);

        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(3) == 0) begin
                do_load(16'($urandom));
            end else begin
                do_op(3'($urandom), int'($urandom_range(15)), 1'($urandom),
                      1'($urandom), 1'($urandom));
            end
        end
        @(posedge clk); #1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
